// File: rtl/uart_host_cmd_master.sv
// rtl/uart_host_cmd_master.sv - SYS_CTRL command master over a byte UART TX/RX pair
// Optional response timeout enabled by defining HOST_CMD_TIMEOUT_EN.
module uart_host_cmd_master #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_data0,
  input  logic [7:0]  cmd_data1,
  input  logic [3:0]  cmd_func,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  localparam logic [1:0] OP_RF_WR  = 2'd0;
  localparam logic [1:0] OP_RF_RD  = 2'd1;
  localparam logic [1:0] OP_ALU_W  = 2'd2;
  localparam logic [1:0] OP_ALU_N  = 2'd3;

  state_t      state;
  logic [1:0]  op_q;
  logic [3:0]  addr_q;
  logic [7:0]  data0_q;
  logic [7:0]  data1_q;
  logic [3:0]  func_q;
  logic [1:0]  idx;
  logic        rx_cnt;
  logic [7:0]  lo_q;

  logic        fin;
  logic [15:0] fin_data;

  function automatic logic [7:0] frame_byte(input logic [1:0] op, input logic [3:0] addr,
                                            input logic [7:0] d0, input logic [7:0] d1,
                                            input logic [3:0] func, input logic [1:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (op)
      OP_RF_WR: case (i)
        2'd0:    b = 8'hAA;
        2'd1:    b = {4'h0, addr};
        default: b = d0;
      endcase
      OP_RF_RD: b = (i == 2'd0) ? 8'hBB : {4'h0, addr};
      OP_ALU_W: case (i)
        2'd0:    b = 8'hCC;
        2'd1:    b = d0;
        2'd2:    b = d1;
        default: b = {4'h0, func};
      endcase
      default:  b = (i == 2'd0) ? 8'hDD : {4'h0, func};
    endcase
    return b;
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] op);
    case (op)
      OP_RF_WR: return 2'd2;
      OP_ALU_W: return 2'd3;
      default:  return 2'd1;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef HOST_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;
  logic        tmo_q;
  logic        fin_tmo;
  assign rsp_timeout = tmo_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Decides when the current command completes and what response it carries.
  always_comb begin
    fin      = 1'b0;
    fin_data = 16'h0000;
`ifdef HOST_CMD_TIMEOUT_EN
    fin_tmo  = 1'b0;
`endif
    if (state == SEND && tx_ready && idx == last_idx(op_q) && op_q == OP_RF_WR) begin
      fin = 1'b1;
    end else if (state == WAIT_RSP && rx_valid) begin
      if (op_q == OP_RF_RD) begin
        fin      = 1'b1;
        fin_data = {8'h00, rx_data};
      end else if (rx_cnt) begin
        fin      = 1'b1;
        fin_data = {rx_data, lo_q};
      end
`ifdef HOST_CMD_TIMEOUT_EN
    end else if (state == WAIT_RSP && tmo_cnt == TMO_LAST) begin
      fin     = 1'b1;
      fin_tmo = 1'b1;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      op_q      <= 2'd0;
      addr_q    <= 4'd0;
      data0_q   <= 8'd0;
      data1_q   <= 8'd0;
      func_q    <= 4'd0;
      idx       <= 2'd0;
      rx_cnt    <= 1'b0;
      lo_q      <= 8'd0;
      tx_data   <= 8'd0;
      tx_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
`ifdef HOST_CMD_TIMEOUT_EN
      tmo_cnt   <= 16'd0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (fin) begin
        state     <= DONE;
        rsp_valid <= 1'b1;
        rsp_data  <= fin_data;
        tx_valid  <= 1'b0;
`ifdef HOST_CMD_TIMEOUT_EN
        tmo_q     <= fin_tmo;
`endif
      end else begin
        case (state)
          IDLE: if (cmd_valid) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            data0_q  <= cmd_data0;
            data1_q  <= cmd_data1;
            func_q   <= cmd_func;
            idx      <= 2'd0;
            rx_cnt   <= 1'b0;
            tx_data  <= frame_byte(cmd_op, cmd_addr, cmd_data0, cmd_data1, cmd_func, 2'd0);
            tx_valid <= 1'b1;
            state    <= SEND;
          end
          SEND: if (tx_ready) begin
            if (idx == last_idx(op_q)) begin
              tx_valid <= 1'b0;
              state    <= WAIT_RSP;
`ifdef HOST_CMD_TIMEOUT_EN
              tmo_cnt  <= 16'd0;
`endif
            end else begin
              idx     <= idx + 2'd1;
              tx_data <= frame_byte(op_q, addr_q, data0_q, data1_q, func_q, idx + 2'd1);
            end
          end
          WAIT_RSP: begin
            // Only the first of two ALU bytes lands here; completing bytes take the fin path.
            if (rx_valid) begin
              lo_q   <= rx_data;
              rx_cnt <= 1'b1;
`ifdef HOST_CMD_TIMEOUT_EN
              tmo_cnt <= 16'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_host_cmd_master.sv
// tb/tb_uart_host_cmd_master.sv - scoreboard bench for uart_host_cmd_master
module tb_uart_host_cmd_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [3:0]  cmd_addr = 4'd0;
  logic [7:0]  cmd_data0 = 8'd0;
  logic [7:0]  cmd_data1 = 8'd0;
  logic [3:0]  cmd_func = 4'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  tx_q[$];
  logic [16:0] rsp_q[$];
  bit          rdy_toggle = 1'b0;

  always #5 CLK = ~CLK;

  uart_host_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data0(cmd_data0), .cmd_data1(cmd_data1), .cmd_func(cmd_func),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial forever begin
    @(posedge CLK);
    #1;
    tx_ready = rdy_toggle ? ~tx_ready : 1'b1;
  end

  always @(negedge CLK) begin
    logic [16:0] e;
    if (!RST) begin
      if (tx_valid) begin
        if (tx_q.size() == 0)      check("tx_extra", 32'd1, 32'd0);
        else if (tx_ready)         check("tx_byte", tx_data, tx_q.pop_front());
        else                       check("tx_hold", tx_data, tx_q[0]);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_extra", 32'd1, 32'd0);
        else begin
          e = rsp_q.pop_front();
          check("rsp_data", rsp_data, e[15:0]);
          check("rsp_timeout", rsp_timeout, e[16]);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d0,
                       input logic [7:0] d1, input logic [3:0] f);
    int w;
    w = 0;
    cmd_op = op; cmd_addr = a; cmd_data0 = d0; cmd_data1 = d1; cmd_func = f;
    cmd_valid = 1'b1;
    case (op)
      2'd0: begin
        tx_q.push_back(8'hAA); tx_q.push_back({4'h0, a}); tx_q.push_back(d0);
        rsp_q.push_back(17'h0);
      end
      2'd1: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, a}); end
      2'd2: begin
        tx_q.push_back(8'hCC); tx_q.push_back(d0); tx_q.push_back(d1);
        tx_q.push_back({4'h0, f});
      end
      default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, f}); end
    endcase
    while (!cmd_ready && w < 100) begin tick(); w++; end
    check("cmd_ready_seen", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_op = ~op; cmd_addr = ~a; cmd_data0 = ~d0; cmd_data1 = ~d1; cmd_func = ~f;
    check("tx_valid_t1", tx_valid, 1);
  endtask

  task automatic wait_tx();
    int w;
    w = 0;
    while (tx_q.size() != 0 && w < 100) begin tick(); w++; end
    check("tx_drain", tx_q.size(), 0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    RST = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // RF_WR with tx_ready held high
    issue(2'd0, 4'd5, 8'h3C, 8'h00, 4'd0);
    repeat (3) tick();
    check("wr_rsp_t4", rsp_valid, 1);
    check("wr_busy_t4", busy, 1);
    tick();
    check("wr_busy_t5", busy, 0);

    // RF_RD with stalling TX
    rdy_toggle = 1'b1;
    issue(2'd1, 4'd2, 8'h00, 8'h00, 4'd0);
    wait_tx();
    rdy_toggle = 1'b0;
    rsp_q.push_back({1'b0, 16'h0081});
    rx_byte(8'h81);
    check("rd_rsp_next", rsp_valid, 1);
    tick();

    // ALU_W_OP with a stray byte during SEND
    issue(2'd2, 4'd0, 8'h10, 8'h20, 4'd0);
    rx_byte(8'h55);
    wait_tx();
    rsp_q.push_back({1'b0, 16'h0030});
    rx_byte(8'h30);
    check("alu_no_early_rsp", rsp_valid, 0);
    tick();
    rx_byte(8'h00);
    check("alu_rsp_next", rsp_valid, 1);
    tick();

    // ALU_NO_OP with a missing second byte
    issue(2'd3, 4'd0, 8'h00, 8'h00, 4'd1);
    wait_tx();
    rx_byte(8'h12);
`ifdef HOST_CMD_TIMEOUT_EN
    rsp_q.push_back({1'b1, 16'h0000});
    repeat (15) tick();
    check("tmo_not_yet", rsp_valid, 0);
    tick();
    check("tmo_rsp", rsp_valid, 1);
    check("tmo_flag", rsp_timeout, 1);
    tick();
`else
    repeat (40) tick();
    check("no_tmo_busy", busy, 1);
    check("no_tmo_rsp", rsp_valid, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
`endif
    check("after_tmo_idle", busy, 0);

    // Reset during the third byte of ALU_W_OP
    issue(2'd2, 4'd0, 8'hA5, 8'h5A, 4'd3);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tx_q.delete();
    check("rst_mid_tx_valid", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    issue(2'd1, 4'd7, 8'h00, 8'h00, 4'd0);
    wait_tx();
    rsp_q.push_back({1'b0, 16'h00C3});
    rx_byte(8'hC3);
    check("rd2_rsp_next", rsp_valid, 1);
    tick();

    // Back-to-back with cmd_valid held high
    cmd_op = 2'd0; cmd_addr = 4'd1; cmd_data0 = 8'h11;
    tx_q.push_back(8'hAA); tx_q.push_back(8'h01); tx_q.push_back(8'h11);
    rsp_q.push_back(17'h0);
    cmd_valid = 1'b1;
    check("b2b_ready0", cmd_ready, 1);
    tick();
    cmd_addr = 4'd2; cmd_data0 = 8'h22;
    tx_q.push_back(8'hAA); tx_q.push_back(8'h02); tx_q.push_back(8'h22);
    rsp_q.push_back(17'h0);
    for (int k = 0; k < 4; k++) begin
      check("b2b_ready_busy", cmd_ready, 0);
      tick();
    end
    check("b2b_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("b2b_second_tx", tx_valid, 1);
    repeat (6) tick();

    check("tx_q_empty", tx_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_host_cmd_master.md
Name: uart_host_cmd_master

Overview:
- Host-side initiator for the SYS_CTRL command protocol carried over UART.
- Takes one command request and serializes it into a UART byte frame on a byte-level TX interface.
- Collects the SYS_CTRL response bytes from a byte-level RX interface and returns a single assembled response.
- Sits in front of a byte UART TX/RX pair in the bench/host subsystem, talking to the system's RX_IN/TX_OUT.

Parameters:
- TIMEOUT_CYCLES, 65535: idle CLK cycles allowed between response bytes before a timeout is declared (1..65535).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  0=RF_WR, 1=RF_RD, 2=ALU_W_OP, 3=ALU_NO_OP
- cmd_addr  in  4  register address
- cmd_data0  in  8  write data / operand A
- cmd_data1  in  8  operand B
- cmd_func  in  4  ALU function
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  byte valid
- tx_ready  in  1  UART TX accepts byte
- rx_data  in  8  byte from UART RX
- rx_valid  in  1  single-cycle pulse, rx_data valid
- rsp_valid  out  1  single-cycle pulse, response complete
- rsp_data  out  16  response payload
- rsp_timeout  out  1  qualifies rsp_valid: response timed out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: tx_valid=0, tx_data=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0, state=IDLE, all counters 0.
- cmd_ready=1 in IDLE, including the first cycle after reset.
- Command fields are latched on acceptance; input changes after acceptance have no effect.
- Frames (address zero-extended to 8 bits, func zero-extended to 8 bits):
  - RF_WR: AA, addr, data0. No response expected.
  - RF_RD: BB, addr. 1 response byte.
  - ALU_W_OP: CC, data0, data1, func. 2 response bytes.
  - ALU_NO_OP: DD, func. 2 response bytes.
- FSM states: IDLE -> SEND -> WAIT_RSP -> DONE -> IDLE. RF_WR goes SEND -> DONE directly.
- SEND:
  - Acceptance at cycle T: tx_valid=1 with byte 0 at T+1.
  - A byte transfers when tx_valid & tx_ready.
  - The next byte is presented the following cycle.
  - tx_data is held stable while tx_valid & !tx_ready.
  - tx_valid drops the cycle after the last byte transfers.
- WAIT_RSP:
  - Each rx_valid captures one byte.
  - ALU response order is LSB first: rsp_data[7:0] = first byte, rsp_data[15:8] = second byte.
  - RF_RD: rsp_data = {8'h00, byte}.
- DONE: single cycle; rsp_valid=1; then IDLE.
  - RF_WR: rsp_valid asserts the cycle after the last tx handshake, with rsp_data=0.
  - Read/ALU: rsp_valid asserts the cycle after the last expected rx_valid.
- rsp_data and rsp_timeout hold their values until the next DONE.
- rx_valid outside WAIT_RSP is ignored: no capture, no state change.
- Reset mid-operation: return to IDLE immediately; partial frame and partial response are discarded; no rsp_valid is generated.

Optional Feature:
- Macro HOST_CMD_TIMEOUT_EN, defined:
  - A 16-bit counter clears on entry to WAIT_RSP and on every rx_valid, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: go to DONE with rsp_timeout=1, rsp_data=0.
  - rx_valid arriving in the same cycle as the terminal count wins: the byte is captured and no timeout occurs.
- Macro not defined:
  - No counter; WAIT_RSP waits indefinitely.
  - rsp_timeout is tied to 0.

Test Plan:
- RF_WR addr=5 data=0x3C, tx_ready=1: tx bytes AA,05,3C on 3 consecutive cycles starting T+1; rsp_valid at T+4 with rsp_data=0x0000 and busy low at T+5.
- RF_RD addr=2, tx_ready toggling 1/0: tx_data held through stalls, bytes BB,02; rx byte 0x81 -> rsp_valid next cycle, rsp_data=0x0081, rsp_timeout=0.
- ALU_W_OP A=0x10 B=0x20 func=0: bytes CC,10,20,00; rx 0x30 then 0x00 -> rsp_data=0x0030. A stray rx byte 0x55 injected during SEND is ignored.
- ALU_NO_OP func=1, rx single byte 0x12 then silence, TIMEOUT_CYCLES=16, macro defined: rsp_valid 16 cycles after that byte with rsp_timeout=1, rsp_data=0. Macro undefined: busy stays 1.
- Reset asserted during the third byte of ALU_W_OP: next cycle tx_valid=0, busy=0, cmd_ready=1, no rsp_valid; a following RF_RD completes normally.
- Back-to-back: cmd_valid held high across two commands: the second is accepted only in the IDLE cycle after DONE, and cmd_ready=0 throughout SEND/WAIT_RSP/DONE.
